// File: rtl/imem_loader.sv
// UART boot loader: receives a length-prefixed program image, writes it into instruction memory
// and holds the core in reset until the image is complete. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  // state  | meaning
  // S_HDR  | collecting the 4-byte word count
  // S_DATA | assembling payload words and writing them
  // S_CSUM | waiting for the checksum byte
  // S_RUN  | image loaded, core released
  // S_ERR  | load failed, core held in reset

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [32:0]      MAX_N     = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_RUN;
`endif

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_vld_q, rx_vld_d;
  logic             rx_ferr;

  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       word_full;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Receiver: samples mid-bit using a down-counter reloaded at each sample point.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_vld_d   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_vld_d = 1'b1;
          else           rx_ferr  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    word_full = {rx_shift_q, word_q[31:8]};
    unique case (state_q)
      S_HDR: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_vld_q) begin
          word_d = word_full;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            rem_d = word_full[ADDR_W:0];
            if ({1'b0, word_full} > MAX_N) state_d = S_ERR;
            else if (word_full == '0)      state_d = S_TAIL;
            else                           state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_vld_q) begin
          word_d = word_full;
          bcnt_d = bcnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_shift_q;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = word_full;
            idx_d   = idx_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_q == (ADDR_W+1)'(1)) state_d = S_TAIL;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_ferr)       state_d = S_ERR;
        else if (rx_vld_q) state_d = (rx_shift_q == csum_q) ? S_RUN : S_ERR;
      end
`endif
      default: ;
    endcase
    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_vld_q   <= 1'b0;
      state_q    <= S_HDR;
      bcnt_q     <= 2'd0;
      word_q     <= 32'd0;
      rem_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_vld_q   <= rx_vld_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
